// File: rtl/bus_register_bank.sv
// Bank of DEPTH registers on a shared tri-state bus: addressed load, drive, inc/dec.
module bus_register_bank #(
   parameter int unsigned         WIDTH       = 8,
   parameter int unsigned         DEPTH       = 4,
   parameter logic [WIDTH-1:0]    RESET_VALUE = '0,
   localparam int unsigned        AW          = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [AW-1:0]            addr,
   input  logic                     read_from_bus,
   input  logic                     write_to_bus,
   input  logic                     inc,
   input  logic                     dec,
   inout  wire  [WIDTH-1:0]         bus,
   output logic [DEPTH*WIDTH-1:0]   values,
   output logic                     zero,
   output logic                     carry,
   output logic                     conflict
);

   localparam int unsigned SLOTS = 1 << AW;

   logic [WIDTH-1:0] regs [DEPTH];
   logic [SLOTS-1:0] valid_map;
   logic             addr_valid;
   logic [AW-1:0]    sel;
   logic [WIDTH-1:0] cur_val;
   logic [WIDTH-1:0] nxt_val;
   logic             load_en;
   logic             carry_nxt;
   logic             conflict_set;

   // Constant map of which address codes name a real register (matters for non-power-of-2 DEPTH)
   for (genvar g = 0; g < SLOTS; g++) begin : g_valid
      assign valid_map[g] = (g < DEPTH) ? 1'b1 : 1'b0;
   end

   assign addr_valid = valid_map[addr];
   assign sel        = addr_valid ? addr : '0;
   assign cur_val    = regs[sel];

   // Bus is driven combinationally with the pre-update value of the addressed register
   assign bus  = (write_to_bus && addr_valid) ? cur_val : {WIDTH{1'bz}};
   assign zero = addr_valid && (cur_val == '0);

   // Flatten register contents onto the observation port
   for (genvar g = 0; g < DEPTH; g++) begin : g_values
      assign values[g*WIDTH +: WIDTH] = regs[g];
   end

   // Per-cycle operation decode, first matching condition wins
   always_comb begin
      load_en      = 1'b0;
      nxt_val      = cur_val;
      carry_nxt    = carry;
      conflict_set = 1'b0;
      if (addr_valid) begin
         if (write_to_bus && read_from_bus) begin
            conflict_set = 1'b1;
         end else if (read_from_bus) begin
            load_en = 1'b1;
            nxt_val = bus;
         end else if (inc && dec) begin
            load_en = 1'b0;
         end else if (inc) begin
            load_en   = 1'b1;
            nxt_val   = cur_val + WIDTH'(1);
            carry_nxt = &cur_val;
         end else if (dec) begin
            load_en   = 1'b1;
            nxt_val   = cur_val - WIDTH'(1);
            carry_nxt = ~|cur_val;
         end
      end
   end

   // Register file and flags; conflict is sticky until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= RESET_VALUE;
         end
         carry    <= 1'b0;
         conflict <= 1'b0;
      end else begin
         if (load_en) begin
            regs[sel] <= nxt_val;
         end
         carry <= carry_nxt;
         if (conflict_set) begin
            conflict <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bus_register_bank.sv
// Scoreboard bench for bus_register_bank (WIDTH=8, DEPTH=4).
module tb_bus_register_bank;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [1:0]  addr;
   logic        read_from_bus;
   logic        write_to_bus;
   logic        inc;
   logic        dec;
   logic [7:0]  bus_drv;
   logic        bus_oe;
   wire  [7:0]  bus;
   logic [31:0] values;
   logic        zero;
   logic        carry;
   logic        conflict;

   exp_t sb[$];
   int   vectors;
   int   miscompares;

   assign bus = bus_oe ? bus_drv : 8'hzz;

   bus_register_bank #(
      .WIDTH       (8),
      .DEPTH       (4),
      .RESET_VALUE (8'h00)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .addr          (addr),
      .read_from_bus (read_from_bus),
      .write_to_bus  (write_to_bus),
      .inc           (inc),
      .dec           (dec),
      .bus           (bus),
      .values        (values),
      .zero          (zero),
      .carry         (carry),
      .conflict      (conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      read_from_bus = 1'b0;
      write_to_bus  = 1'b0;
      inc           = 1'b0;
      dec           = 1'b0;
      bus_oe        = 1'b0;
   endtask

   task automatic load(input logic [1:0] a, input logic [7:0] d);
      addr = a; bus_drv = d; bus_oe = 1'b1; read_from_bus = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_reset();
      exp_t e;
      logic [31:0] obs;
      sb.push_back('{"rst_values", 32'h0000_0000});
      sb.push_back('{"rst_carry", 32'h0});
      sb.push_back('{"rst_conflict", 32'h0});
      sb.push_back('{"rst_zero", 32'h1});
      #1;
      e = sb.pop_front(); vectors++; obs = values;
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      e = sb.pop_front(); vectors++; obs = 32'(carry);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      e = sb.pop_front(); vectors++; obs = 32'(conflict);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      e = sb.pop_front(); vectors++; obs = 32'(zero);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      @(negedge clk);
      rst = 1'b0;

      // Reset asserted mid-increment clears reg1 immediately
      load(2'd1, 8'h05);
      sb.push_back('{"pre_rst_reg1", 32'h05});
      e = sb.pop_front(); vectors++; obs = 32'(values[15:8]);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      addr = 2'd1; inc = 1'b1;
      #3 rst = 1'b1;
      sb.push_back('{"mid_rst_reg1", 32'h00});
      #1;
      e = sb.pop_front(); vectors++; obs = 32'(values[15:8]);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      sb.push_back('{"rst_held_reg1", 32'h00});
      tick();
      e = sb.pop_front(); vectors++; obs = 32'(values[15:8]);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      idle();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_load_drive();
      exp_t e;
      logic [31:0] obs;
      sb.push_back('{"load_values", 32'h00A5_0000});
      load(2'd2, 8'hA5);
      e = sb.pop_front(); vectors++; obs = values;
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      addr = 2'd2; write_to_bus = 1'b1;
      sb.push_back('{"drive_bus", 32'hA5});
      sb.push_back('{"drive_zero", 32'h0});
      #1;
      e = sb.pop_front(); vectors++; obs = 32'(bus);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      e = sb.pop_front(); vectors++; obs = 32'(zero);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      sb.push_back('{"drive_hold", 32'h00A5_0000});
      tick();
      e = sb.pop_front(); vectors++; obs = values;
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      idle();
   endtask

   task automatic test_inc_wrap();
      exp_t e;
      logic [31:0] obs;
      load(2'd0, 8'hFE);
      addr = 2'd0; inc = 1'b1;
      sb.push_back('{"inc1_reg0", 32'hFF});
      sb.push_back('{"inc1_carry", 32'h0});
      tick();
      e = sb.pop_front(); vectors++; obs = 32'(values[7:0]);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      e = sb.pop_front(); vectors++; obs = 32'(carry);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      sb.push_back('{"inc2_reg0", 32'h00});
      sb.push_back('{"inc2_carry", 32'h1});
      sb.push_back('{"inc2_zero", 32'h1});
      tick();
      e = sb.pop_front(); vectors++; obs = 32'(values[7:0]);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      e = sb.pop_front(); vectors++; obs = 32'(carry);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      e = sb.pop_front(); vectors++; obs = 32'(zero);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      idle();
   endtask

   task automatic test_dec_borrow();
      exp_t e;
      logic [31:0] obs;
      addr = 2'd3; dec = 1'b1;
      sb.push_back('{"dec1_reg3", 32'hFF});
      sb.push_back('{"dec1_carry", 32'h1});
      tick();
      e = sb.pop_front(); vectors++; obs = 32'(values[31:24]);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      e = sb.pop_front(); vectors++; obs = 32'(carry);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      sb.push_back('{"dec2_reg3", 32'hFE});
      sb.push_back('{"dec2_carry", 32'h0});
      tick();
      e = sb.pop_front(); vectors++; obs = 32'(values[31:24]);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      e = sb.pop_front(); vectors++; obs = 32'(carry);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      idle();
   endtask

   task automatic test_priority();
      exp_t e;
      logic [31:0] obs;
      load(2'd1, 8'h10);
      addr = 2'd1; bus_drv = 8'h33; bus_oe = 1'b1; read_from_bus = 1'b1; inc = 1'b1;
      sb.push_back('{"load_over_inc", 32'h33});
      tick();
      e = sb.pop_front(); vectors++; obs = 32'(values[15:8]);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      idle();
      inc = 1'b1; dec = 1'b1;
      sb.push_back('{"inc_dec_hold", 32'h33});
      tick();
      e = sb.pop_front(); vectors++; obs = 32'(values[15:8]);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      idle();
      write_to_bus = 1'b1; inc = 1'b1;
      sb.push_back('{"drive_pre_inc", 32'h33});
      #1;
      e = sb.pop_front(); vectors++; obs = 32'(bus);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      sb.push_back('{"drive_post_inc", 32'h34});
      sb.push_back('{"bus_post_inc", 32'h34});
      tick();
      e = sb.pop_front(); vectors++; obs = 32'(values[15:8]);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      e = sb.pop_front(); vectors++; obs = 32'(bus);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      idle();
   endtask

   task automatic test_conflict();
      exp_t e;
      logic [31:0] obs;
      load(2'd0, 8'h7C);
      sb.push_back('{"no_conflict_yet", 32'h0});
      e = sb.pop_front(); vectors++; obs = 32'(conflict);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      addr = 2'd0; read_from_bus = 1'b1; write_to_bus = 1'b1;
      sb.push_back('{"conflict_bus", 32'h7C});
      #1;
      e = sb.pop_front(); vectors++; obs = 32'(bus);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      sb.push_back('{"conflict_reg0", 32'h7C});
      sb.push_back('{"conflict_set", 32'h1});
      tick();
      e = sb.pop_front(); vectors++; obs = 32'(values[7:0]);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      e = sb.pop_front(); vectors++; obs = 32'(conflict);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      idle();
      sb.push_back('{"conflict_sticky", 32'h1});
      tick();
      tick();
      e = sb.pop_front(); vectors++; obs = 32'(conflict);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      rst = 1'b1;
      sb.push_back('{"conflict_cleared", 32'h0});
      #1;
      e = sb.pop_front(); vectors++; obs = 32'(conflict);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [31:0] obs;
      // Ops every cycle on reg2, expected results queued up front
      sb.push_back('{"b2b_inc1", 32'h01});
      sb.push_back('{"b2b_inc2", 32'h02});
      sb.push_back('{"b2b_dec", 32'h01});
      addr = 2'd2; inc = 1'b1;
      tick();
      e = sb.pop_front(); vectors++; obs = 32'(values[23:16]);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      tick();
      e = sb.pop_front(); vectors++; obs = 32'(values[23:16]);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      inc = 1'b0; dec = 1'b1;
      tick();
      e = sb.pop_front(); vectors++; obs = 32'(values[23:16]);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      addr = 2'd3;
      sb.push_back('{"b2b_switch_values", 32'hFF01_0000});
      sb.push_back('{"b2b_switch_carry", 32'h1});
      tick();
      e = sb.pop_front(); vectors++; obs = values;
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      e = sb.pop_front(); vectors++; obs = 32'(carry);
      if (obs !== e.val) begin miscompares++; $display("FAIL %s got %h exp %h", e.name, obs, e.val); end
      idle();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      addr        = 2'd0;
      bus_drv     = 8'h00;
      idle();
      test_reset();
      test_load_drive();
      test_inc_wrap();
      test_dec_borrow();
      test_priority();
      test_conflict();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bus_register_bank.md
# bus_register_bank

Parametrised bank of DEPTH general-purpose registers, each WIDTH bits, sharing the CPU's single tri-state data bus. It generalises the single bus register: one addressed register per cycle can load from the bus, drive the bus, or increment/decrement in place. Carry and conflict flags are registered; the zero flag is combinational. The bank sits on the main bus beside the ALU and RAM and serves as the A/B/temp/pointer registers under control-unit microcode.

## Interface
- WIDTH, 8, bits per register and bus width
- DEPTH, 4, number of registers (≥2); AW = $clog2(DEPTH)
- RESET_VALUE, 0, value loaded into every register on reset
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- addr  in  AW  selects the register for all operations this cycle
- read_from_bus  in  1  load bus into reg[addr] at next rising edge
- write_to_bus  in  1  drive reg[addr] onto bus this cycle
- inc  in  1  reg[addr] <= reg[addr] + 1 (modulo 2^WIDTH)
- dec  in  1  reg[addr] <= reg[addr] - 1 (modulo 2^WIDTH)
- bus  inout  WIDTH  shared tri-state data bus
- values  out  DEPTH*WIDTH  all register contents; reg i at [i*WIDTH +: WIDTH]
- zero  out  1  reg[addr] == 0, combinational
- carry  out  1  registered wrap flag from last inc/dec
- conflict  out  1  sticky error flag

## Operation
- Bus drive: bus = reg[addr] while write_to_bus=1, else all-Z. Purely combinational; no registered delay.
- Per-edge action on reg[addr], first matching row wins:
  - write_to_bus=1 and read_from_bus=1: no load; bus still driven; conflict <= 1.
  - read_from_bus=1: reg[addr] <= bus. Takes priority over inc/dec; carry unchanged.
  - inc=1 and dec=1: no change; carry unchanged.
  - inc=1: reg <= reg+1; carry <= (reg == 2^WIDTH-1).
  - dec=1: reg <= reg-1; carry <= (reg == 0), i.e. borrow.
  - none: hold.
- Registers other than reg[addr] always hold.
- write_to_bus may combine with inc or dec: the bus shows the pre-update value, and the register updates at the edge.
- A bus value that is X/Z during a load is stored as sampled; this is not checked.
- conflict stays 1 until reset. No other clear.
- addr ≥ DEPTH (non-power-of-2 DEPTH): all operations ignored, bus Z, zero=0, conflict unaffected.

## Timing
- Reset (async assert, immediate): every register = RESET_VALUE, carry=0, conflict=0, bus Z. zero reflects RESET_VALUE (1 when 0).
- Reset asserted mid-operation overrides any pending load/inc/dec. Release is synchronous to the next clk edge with no action on that release edge if rst is still high at the edge.
- Load/inc/dec latency: 1 cycle; new value visible on values and bus (if driven) after the rising edge.
- Bus drive latency: 0 cycles from write_to_bus/addr change.
- carry/conflict update at the same edge as the register.
- zero follows addr and register contents combinationally.
- Back-to-back operations on the same register every cycle are legal. The second op sees the first op's result.

## Test plan
- Reset: after reset, values=0x00000000, carry=0, conflict=0, zero=1, bus=Z; assert rst mid-inc with reg1=0x05 -> reg1=0x00 immediately.
- Load/drive: bus_driver=0xA5, addr=2, read_from_bus=1 for 1 cycle -> values[23:16]=0xA5. Then write_to_bus=1 -> bus=0xA5 same cycle, other regs unchanged.
- Increment wrap: load reg0=0xFE, inc for 2 cycles -> 0xFF with carry=0, then 0x00 with carry=1, zero=1.
- Decrement borrow: reg3=0x00, dec 1 cycle -> 0xFF, carry=1. Then dec -> 0xFE, carry=0.
- Priority: reg1=0x10, bus=0x33, read_from_bus=1 with inc=1 -> 0x33. inc=dec=1 -> stays 0x33. write_to_bus+inc -> bus shows 0x33, reg becomes 0x34.
- Conflict: read_from_bus=write_to_bus=1 on reg0=0x7C -> bus=0x7C, reg0 stays 0x7C, conflict=1 next edge and stays 1 until rst.
